multi_cycle_adder_32: RTL and testbench
=======================================

MULTI_CYCLE_ADDER_32 -- requirements
Module: multi_cycle_adder_32

Interface
REQ-001 The block SHALL use one clock, clk; reset is synchronous and active-high (reset), sampled on the rising edge of clk.
REQ-002 Port list SHALL be:
  clk      input   1   system clock, rising edge active
  reset    input   1   synchronous active-high reset
  start    input   1   request; sampled only in IDLE
  sub      input   1   0 = a+b, 1 = a-b; latched with start
  a        input   32  operand A; latched with start
  b        input   32  operand B; latched with start
  busy     output  1   high while in RUN
  done     output  1   one-cycle completion pulse
  result   output  32  sum or difference
  c_out    output  1   carry out of bit 31; for subtraction, 1 = no borrow
  overflow output  1   signed two's-complement overflow
  zero     output  1   result == 0
REQ-003 Parameter: NIBBLES, default 8, number of 4-bit steps; operand width is 4*NIBBLES.

Function
REQ-004 The block SHALL compute the 32-bit add or subtract iteratively, one 4-bit slice per cycle, through a single 4-bit carry-lookahead adder.
REQ-005 FSM states SHALL be IDLE, RUN and DONE.
REQ-006 Transitions SHALL be: IDLE->RUN on start=1; RUN->DONE on the edge that processes nibble NIBBLES-1; DONE->IDLE unconditionally after one cycle.
REQ-007 On start acceptance, the block SHALL latch a, b and sub, load the effective B as b XOR {32{sub}}, set the carry register to sub, and clear the nibble index to 0.
REQ-008 Each RUN edge SHALL add nibble[idx] of A, nibble[idx] of effective B and the carry register.
REQ-009 On the same RUN edge, the 4-bit sum SHALL be written into result[4*idx+3:4*idx], the carry register SHALL take the 4-bit c_out, and idx SHALL increment.
REQ-010 Latency: with start accepted at edge N, done SHALL be high during the cycle after edge N+8, and busy SHALL be high during the cycles after edges N through N+7.
REQ-011 done SHALL be high only in DONE, for exactly one cycle per accepted operation.
REQ-012 start SHALL be ignored in RUN and DONE, with no queuing; a new operation may be accepted only on the edge after DONE.
REQ-013 Operand inputs SHALL be don't-care except on the accepting edge.
REQ-014 c_out SHALL equal the final carry register value.
REQ-015 overflow SHALL be (A[31] == Beff[31]) AND (result[31] != A[31]).
REQ-016 zero SHALL be (result == 0).
REQ-017 c_out, overflow and zero SHALL be valid in DONE.
REQ-018 result, c_out, overflow and zero SHALL hold their values from DONE until the next start is accepted; result bits are undefined-but-stable during RUN.
REQ-019 Wrap-around: idx SHALL be 3 bits wide; the final increment from 7 to 0 SHALL be harmless because the state is DONE.

Reset
REQ-020 While reset=1 at a clock edge, state SHALL become IDLE, and idx, the carry register, result, c_out, overflow, busy and done SHALL all become 0; zero SHALL become 1.
REQ-021 Reset SHALL take priority over start and over RUN progress.
REQ-022 Reset asserted mid-operation SHALL abort it with no done pulse.
REQ-023 After reset deasserts, the next start SHALL be accepted normally.

Structure
REQ-024 A shared package SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), the nibble width constant (4) and the default NIBBLES.
REQ-025 The block SHALL instantiate exactly one existing CarryLookaheadAdder4Bit as its sub-module.
REQ-026 Nibble select and result write-back SHALL be implemented in this block.

Verification
REQ-027 Add: a=1, b=2, sub=0, start pulse -> done 9 cycles later; result=3, c_out=0, overflow=0, zero=0.
REQ-028 Carry chain: a=0xFFFFFFFF, b=1, sub=0 -> result=0, c_out=1, zero=1, overflow=0.
REQ-029 Signed overflow: a=0x7FFFFFFF, b=1, sub=0 -> result=0x80000000, overflow=1, c_out=0.
REQ-030 Subtract: a=5, b=7, sub=1 -> result=0xFFFFFFFE, c_out=0 (borrow), overflow=0; then a=7, b=5, sub=1 -> result=2, c_out=1.
REQ-031 Ignore-while-busy: start a=3, b=11; re-pulse start with a=100 at cycle 3 -> exactly one done pulse, result=14.
REQ-032 Reset mid-op: start, then reset at cycle 4 -> no done pulse; all outputs reset per REQ-020; a new start then completes correctly.

Source files
------------

// File: rtl/multi_cycle_adder_32_pkg.sv
// Shared definitions for the nibble-serial adder: state encoding and slice sizing.
package multi_cycle_adder_32_pkg;

    localparam int NIBBLE_W        = 4;
    localparam int NIBBLES_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/multi_cycle_adder_32_cla.sv
// Single 4-bit carry-lookahead adder slice reused for every nibble of the operation.
module CarryLookaheadAdder4Bit
    import multi_cycle_adder_32_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                c_i,
    output logic [NIBBLE_W-1:0] sum_o,
    output logic                c_o
);

    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W:0]   c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Every carry is expanded from generate/propagate terms, no ripple between bits
    assign c[0] = c_i;
    assign c[1] = g[0] | (p[0] & c_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_i);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_i);

    assign sum_o = p ^ c[NIBBLE_W-1:0];
    assign c_o   = c[NIBBLE_W];

endmodule

// File: rtl/multi_cycle_adder_32.sv
// Iterative add/subtract: one nibble per RUN cycle through a shared CLA slice,
// status flags derived from the held operands and result.
module multi_cycle_adder_32
    import multi_cycle_adder_32_pkg::*;
#(
    parameter int NIBBLES = NIBBLES_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       sub,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    output logic                       busy,
    output logic                       done,
    output logic [NIBBLE_W*NIBBLES-1:0] result,
    output logic                       c_out,
    output logic                       overflow,
    output logic                       zero
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     beff_q, beff_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     result_q, result_d;

    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_c;

    assign nib_a = a_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];
    assign nib_b = beff_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];

    CarryLookaheadAdder4Bit u_cla (
        .a_i   (nib_a),
        .b_i   (nib_b),
        .c_i   (carry_q),
        .sum_o (nib_sum),
        .c_o   (nib_c)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        beff_d  = beff_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    beff_d  = b ^ {W{sub}};
                    carry_d = sub;
                    idx_d   = '0;
                end
            end
            RUN: begin
                carry_d = nib_c;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Only the nibble currently addressed is rewritten; the rest hold
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_wb
        assign result_d[gi*NIBBLE_W +: NIBBLE_W] =
            (state_q == RUN && idx_q == IDX_W'(gi)) ? nib_sum
                                                    : result_q[gi*NIBBLE_W +: NIBBLE_W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            beff_q   <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            beff_q   <= beff_d;
            carry_q  <= carry_d;
            result_q <= result_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign result   = result_q;
    assign c_out    = carry_q;
    assign overflow = (a_q[W-1] == beff_q[W-1]) && (result_q[W-1] != a_q[W-1]);
    assign zero     = (result_q == '0);

endmodule

// File: tb/tb_multi_cycle_adder_32.sv
// Directed checks of the nibble-serial adder: arithmetic, flags, latency, busy-ignore, reset abort.
module tb_multi_cycle_adder_32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        c_out;
    logic        overflow;
    logic        zero;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    multi_cycle_adder_32 dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .c_out    (c_out),
        .overflow (overflow),
        .zero     (zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "/busy"},     32'(busy),     32'd0);
        chk({tag, "/done"},     32'(done),     32'd0);
        chk({tag, "/result"},   result,        32'd0);
        chk({tag, "/c_out"},    32'(c_out),    32'd0);
        chk({tag, "/overflow"}, 32'(overflow), 32'd0);
        chk({tag, "/zero"},     32'(zero),     32'd1);
    endtask

    // One full operation from an IDLE cycle; expectations are hand-computed by the caller
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic ts, input logic [31:0] er, input logic ec,
                          input logic eo, input logic ez);
        int lat;
        int busy_cnt;
        bit got;
        start = 1'b1; a = ta; b = tb_v; sub = ts;
        step();
        start = 1'b0; a = $urandom; b = $urandom; sub = 1'($urandom);
        chk({tag, "/busy_on_accept"}, 32'(busy), 32'd1);
        busy_cnt = busy ? 1 : 0;
        lat = 0;
        got = 1'b0;
        while (lat < 20 && !got) begin
            step();
            lat++;
            if (done) got = 1'b1;
            else if (busy) busy_cnt++;
        end
        chk({tag, "/done_seen"},   32'(got),      32'd1);
        chk({tag, "/latency"},     32'(lat),      32'd8);
        chk({tag, "/busy_cycles"}, 32'(busy_cnt), 32'd8);
        chk({tag, "/busy_in_done"}, 32'(busy),    32'd0);
        chk({tag, "/result"},      result,        er);
        chk({tag, "/c_out"},       32'(c_out),    32'(ec));
        chk({tag, "/overflow"},    32'(overflow), 32'(eo));
        chk({tag, "/zero"},        32'(zero),     32'(ez));
        step();
        chk({tag, "/done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, "/result_hold"},    result,    er);
        chk({tag, "/zero_hold"},      32'(zero), 32'(ez));
        $display("[TB] op %s a=%h b=%h sub=%0d -> result=%h c_out=%0d ovf=%0d zero=%0d lat=%0d",
                 tag, ta, tb_v, ts, result, c_out, overflow, zero, lat);
    endtask

    initial begin
        int pulses;
        int n;
        logic [31:0] res_seen;

        reset = 1'b1; start = 1'b1; sub = 1'b0; a = 32'd9; b = 32'd9;
        step();
        step();
        chk_reset_outputs("reset_with_start");
        $display("[TB] reset applied with start high");
        reset = 1'b0; start = 1'b0;
        step();

        run_op("add_1_2",      32'd1,        32'd2,        1'b0, 32'd3,        1'b0, 1'b0, 1'b0);
        run_op("carry_chain",  32'hFFFFFFFF, 32'd1,        1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
        run_op("signed_ovf",   32'h7FFFFFFF, 32'd1,        1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        run_op("sub_5_7",      32'd5,        32'd7,        1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_7_5",      32'd7,        32'd5,        1'b1, 32'd2,        1'b1, 1'b0, 1'b0);
        run_op("sub_neg_ovf",  32'h80000000, 32'd1,        1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        run_op("sub_equal",    32'd5,        32'd5,        1'b1, 32'd0,        1'b1, 1'b0, 1'b1);
        run_op("add_mixed",    32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 1'b0);

        // Second start during RUN must be dropped
        start = 1'b1; a = 32'd3; b = 32'd11; sub = 1'b0;
        step();
        start = 1'b0;
        step();
        step();
        start = 1'b1; a = 32'd100; b = 32'd100;
        step();
        start = 1'b0;
        pulses = 0;
        res_seen = 32'hDEADBEEF;
        for (int i = 0; i < 16; i++) begin
            step();
            if (done) begin
                pulses++;
                res_seen = result;
            end
        end
        chk("ignore_busy/pulses", 32'(pulses), 32'd1);
        chk("ignore_busy/result", res_seen,    32'd14);
        $display("[TB] op ignore_busy pulses=%0d result=%h", pulses, res_seen);

        // Abort mid-operation
        start = 1'b1; a = 32'h0F0F0F0F; b = 32'h01010101; sub = 1'b0;
        step();
        start = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_reset_outputs("reset_midop");
        n = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done) n++;
        end
        chk("reset_midop/no_done", 32'(n), 32'd0);
        $display("[TB] op reset_midop done_pulses=%0d", n);

        run_op("after_reset",  32'h0F0F0F0F, 32'h01010101, 1'b0, 32'h10101010, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
